// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// Holds the FSM state enum and the magnitude helper.
package div_pkg;

  localparam int MAX_W = 64;
  localparam int ST_W  = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  // value must arrive sign-extended to MAX_W when is_signed=1
  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] value,
    input logic             is_signed
  );
    return (is_signed && value[MAX_W-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider.
// master: requester (start, operands); slave: divider (status, results).
interface seq_divider_if #(
  parameter int W = 32
);
  logic           start;
  logic           is_signed;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic [2*W-1:0] z_out;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero,
    input  quotient, remainder, z_out
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero,
    output quotient, remainder, z_out
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
// rem_i/quo_i/dvs_i in; shifted and conditionally restored rem_o/quo_o out.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   sh;
  logic [W+1:0] diff;

  assign sh   = {rem_i, quo_i[W-1]};
  // extra top bit is the borrow: set when the trial went negative
  assign diff = {1'b0, sh} - {2'b00, dvs_i};

  assign rem_o = W'(diff[W+1] ? sh : diff[W:0]);
  assign quo_o = {quo_i[W-2:0], ~diff[W+1]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// clock/clear plain ports; request and results on seq_divider_if.slave.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = 32
) (
  input logic          clock,
  input logic          clear,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(W + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zdiv_q, zdiv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     remd_q, remd_d;

  logic [W-1:0]     a_mag, b_mag;
  logic [W-1:0]     rem_s, quo_s;
  logic             dvs_zero;

  assign a_mag = W'(abs_w(bus.is_signed ? MAX_W'($signed(bus.dividend))
                                        : MAX_W'(bus.dividend),
                          bus.is_signed));
  assign b_mag = W'(abs_w(bus.is_signed ? MAX_W'($signed(bus.divisor))
                                        : MAX_W'(bus.divisor),
                          bus.is_signed));
  assign dvs_zero = (bus.divisor == '0);

  div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_s),
    .quo_o (quo_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zdiv_d  = zdiv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = dvs_zero ? FIX : RUN;
          qneg_d  = bus.is_signed &
                    (bus.dividend[W-1] ^ bus.divisor[W-1]);
          rneg_d  = bus.is_signed & bus.dividend[W-1];
          rem_d   = '0;
          // zero divisor keeps the raw dividend for the remainder
          quo_d   = dvs_zero ? bus.dividend : a_mag;
          dvs_d   = b_mag;
          zdiv_d  = dvs_zero;
          cnt_d   = CNT_W'(W);
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
        end
      end
      RUN: begin
        rem_d = rem_s;
        quo_d = quo_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zdiv_q) begin
          quot_d = '1;
          remd_d = quo_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = qneg_q ? -quo_q : quo_q;
          remd_d = rneg_q ? -rem_q : rem_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zdiv_q  <= zdiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.z_out       = {remd_q, quot_q};

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (W=32 and W=8 instances).
// Drives on negedge / #1 after posedge, samples #1 after posedge.
module tb_seq_divider;

  logic clk;
  logic clear;
  int   checks;
  int   errors;
  int   lat;
  int   pulses;

  seq_divider_if #(.W(32)) b32 ();
  seq_divider_if #(.W(8))  b8 ();

  seq_divider #(.W(32)) u_d32 (
    .clock (clk),
    .clear (clear),
    .bus   (b32)
  );

  seq_divider #(.W(8)) u_d8 (
    .clock (clk),
    .clear (clear),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go32(input logic sgn,
                      input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    b32.start     = 1'b1;
    b32.is_signed = sgn;
    b32.dividend  = a;
    b32.divisor   = b;
    @(negedge clk);
    b32.start     = 1'b0;
  endtask

  task automatic wait32(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!b32.done && n < 200);
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!b8.done && n < 100);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    b32.start = 1'b0; b32.is_signed = 1'b0;
    b32.dividend = '0; b32.divisor = '0;
    b8.start = 1'b0; b8.is_signed = 1'b0;
    b8.dividend = '0; b8.divisor = '0;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 64'(b32.busy), 64'd0);
    chk("rst_done", 64'(b32.done), 64'd0);
    chk("rst_dbz",  64'(b32.div_by_zero), 64'd0);
    chk("rst_z",    b32.z_out, 64'd0);

    // unsigned 26/5
    go32(1'b0, 32'd26, 32'd5);
    wait32(lat);
    chk("u26_lat",  64'(lat), 64'd33);
    chk("u26_done", 64'(b32.done), 64'd1);
    chk("u26_busy", 64'(b32.busy), 64'd0);
    chk("u26_q",    64'(b32.quotient), 64'd5);
    chk("u26_r",    64'(b32.remainder), 64'd1);
    chk("u26_z",    b32.z_out, 64'h00000001_00000005);
    @(posedge clk); #1;
    chk("u26_pulse", 64'(b32.done), 64'd0);

    // signed -26/5
    go32(1'b1, 32'hFFFFFFE6, 32'd5);
    wait32(lat);
    chk("sn26_lat", 64'(lat), 64'd33);
    chk("sn26_q", 64'(b32.quotient), 64'hFFFFFFFB);
    chk("sn26_r", 64'(b32.remainder), 64'hFFFFFFFF);

    // signed 26/-5
    go32(1'b1, 32'd26, 32'hFFFFFFFB);
    wait32(lat);
    chk("s26n_q", 64'(b32.quotient), 64'hFFFFFFFB);
    chk("s26n_r", 64'(b32.remainder), 64'd1);

    // divide by zero
    go32(1'b0, 32'd30, 32'd0);
    wait32(lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_flag", 64'(b32.div_by_zero), 64'd1);
    chk("dz_q", 64'(b32.quotient), 64'hFFFFFFFF);
    chk("dz_r", 64'(b32.remainder), 64'd30);
    go32(1'b0, 32'd100, 32'd7);
    wait32(lat);
    chk("dz_clr", 64'(b32.div_by_zero), 64'd0);
    chk("u100_q", 64'(b32.quotient), 64'd14);
    chk("u100_r", 64'(b32.remainder), 64'd2);

    // signed overflow
    go32(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait32(lat);
    chk("ovf_q", 64'(b32.quotient), 64'h80000000);
    chk("ovf_r", 64'(b32.remainder), 64'd0);
    chk("ovf_dbz", 64'(b32.div_by_zero), 64'd0);

    // clear at edge 10 of a run
    go32(1'b0, 32'd26, 32'd5);
    repeat (9) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b32.done) pulses++;
    end
    chk("clr_pulses", 64'(pulses), 64'd0);
    chk("clr_busy", 64'(b32.busy), 64'd0);
    chk("clr_z", b32.z_out, 64'd0);
    chk("clr_dbz", 64'(b32.div_by_zero), 64'd0);
    go32(1'b0, 32'd100, 32'd7);
    wait32(lat);
    chk("clr_lat", 64'(lat), 64'd33);
    chk("clr_q", 64'(b32.quotient), 64'd14);
    chk("clr_r", 64'(b32.remainder), 64'd2);

    // W=8: 200/7 with an ignored start while busy
    @(negedge clk);
    b8.start     = 1'b1;
    b8.is_signed = 1'b0;
    b8.dividend  = 8'd200;
    b8.divisor   = 8'd7;
    @(negedge clk);
    b8.start     = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin
        b8.start    = 1'b1;
        b8.dividend = 8'd50;
        b8.divisor  = 8'd5;
      end
      if (lat == 3) b8.start = 1'b0;
    end while (!b8.done && lat < 100);
    chk("w8_lat", 64'(lat), 64'd9);
    chk("w8_q", 64'(b8.quotient), 64'd28);
    chk("w8_r", 64'(b8.remainder), 64'd4);

    // back-to-back start in the done cycle: 50/3
    b8.start    = 1'b1;
    b8.dividend = 8'd50;
    b8.divisor  = 8'd3;
    @(posedge clk); #1;
    b8.start = 1'b0;
    chk("w8_drop", 64'(b8.done), 64'd0);
    chk("w8_busy", 64'(b8.busy), 64'd1);
    wait8(lat);
    chk("w8b_lat", 64'(lat), 64'd9);
    chk("w8b_q", 64'(b8.quotient), 64'd16);
    chk("w8b_r", 64'(b8.remainder), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle restoring divider that replaces the single-shot divide path behind the ALU's Z register. It accepts a start pulse and operands, iterates one quotient bit per clock, and returns quotient and remainder packed as {remainder, quotient}, so Z-high feeds HI and Z-low feeds LO. It is parametrised in width, supports signed and unsigned operation, and flags divide-by-zero. The datapath controller waits on done instead of assuming a fixed T-state.

Parameters:
W, 32, operand width in bits; legal range W >= 2
CNT_W, $clog2(W+1), localparam; iteration counter width; not overridable

Ports:
clock  in  1  system clock; all state updates on rising edge
clear  in  1  synchronous active-high reset
start  in  1  request; sampled only when busy=0
is_signed  in  1  1 = two's-complement divide; 0 = unsigned; sampled with start
dividend  in  W  numerator; sampled with start
divisor  in  W  denominator; sampled with start
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse; results valid from this cycle onward
div_by_zero  out  1  set with done when divisor was 0; held until next accepted start
quotient  out  W  result quotient; held until next accepted start
remainder  out  W  result remainder; held until next accepted start
z_out  out  2W  {remainder, quotient}; upper half goes to HI, lower half to LO

Behaviour:
- Reset (clear=1 at an edge): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
- Reset mid-operation: the operation is abandoned; done never pulses for it. clear has priority over start.
- States:
  - IDLE: start=1 -> RUN, or -> FIX if divisor==0.
  - RUN: W iterations, then -> FIX.
  - FIX: always -> IDLE.
- Accept edge, start=1 in IDLE:
  - latch sign_q = is_signed & (dividend[W-1] ^ divisor[W-1]) and sign_r = is_signed & dividend[W-1];
  - load |dividend| and |divisor| (absolute values only when is_signed=1);
  - partial remainder = 0; counter = W; busy=1; div_by_zero=0.
- RUN, one iteration per edge:
  - shift {rem, quo} left by 1; trial = rem - divisor_mag, computed in W+1 bits;
  - if trial >= 0: rem = trial and quo[0] = 1, else quo[0] = 0;
  - counter decrements; when counter reaches 1 on this edge, next state = FIX.
- FIX edge:
  - quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem;
  - busy=0, done=1; state -> IDLE.
- Latency: accept at edge 0; iterations at edges 1..W; FIX at edge W+1; done high for the cycle after edge W+1. With W=32, done comes 33 cycles after the accept edge.
- Signed semantics: quotient truncates toward zero; a nonzero remainder takes the sign of the dividend.
- Overflow, signed (-2^(W-1)) / (-1): quotient = 2^(W-1) bit pattern (wraps), remainder = 0; no flag raised.
- Divide-by-zero:
  - accept edge routes directly to FIX;
  - FIX edge sets quotient = all ones, remainder = dividend (raw, as sampled), div_by_zero=1, done=1;
  - done high the cycle after edge 1.
- start while busy=1: ignored, with no effect on state or operands.
- start in the cycle where done=1 (state is IDLE): accepted; done drops at the next edge.
- done is a pulse: low in every cycle except the one following FIX.
- z_out is combinational concatenation of the registered outputs.

Decomposition:
- Shared package div_pkg holds the state enum (IDLE, RUN, FIX), the state encoding width, and a function abs_w(value, is_signed).
- Sub-module div_step: combinational single iteration. Inputs rem, quo, divisor_mag; outputs next rem, quo. It is reused by a future radix-4 variant.
- The FSM and registers stay in seq_divider.

Test Plan:
- W=32, unsigned 26/5 -> 33 cycles after accept: done=1, quotient=5, remainder=1, z_out=64'h00000001_00000005, busy low the same cycle.
- W=32, signed -26/5 -> quotient=32'hFFFFFFFB, remainder=32'hFFFFFFFF. Signed 26/-5 -> quotient=32'hFFFFFFFB, remainder=1.
- W=32, divisor=0, dividend=30 -> done the cycle after edge 1, div_by_zero=1, quotient=32'hFFFFFFFF, remainder=30. The next normal divide clears div_by_zero.
- W=32, signed 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, div_by_zero=0.
- Assert clear at edge 10 of a 26/5 run -> no done pulse, all outputs 0. A new start of 100/7 afterwards -> quotient=14, remainder=2.
- W=8 instance, unsigned 200/7 -> done 9 cycles after accept, quotient=28, remainder=4. A second start issued while busy is ignored. A back-to-back start during the done cycle is accepted.
